serial_paralelo: RTL and testbench
==================================

SERIAL_PARALELO -- requirements
Module: serial_paralelo

Interface
REQ-001 Parameter COM, default 8'hBC, comma symbol the transmitter sends while inactive.
REQ-002 Parameter IDL, default 8'h7C, idle symbol the transmitter sends while active with no valid data.
REQ-003 Parameter BC_REQ, default 4, number of consecutive byte-aligned COM symbols required to declare the lane active.
REQ-004 clk_32f  input  1  single bit clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (0 = reset), sampled on the clk_32f rising edge.
REQ-006 data_in  input  1  serial lane bit, MSB of each byte first.
REQ-007 data_out  output  8  last recovered data byte.
REQ-008 valid_out  output  1  high while data_out holds a data byte (not COM or IDL).
REQ-009 byte_strobe  output  1  one-cycle pulse at every byte boundary while active.
REQ-010 active  output  1  lane aligned and active.

Function
REQ-011 A 7-bit shift register shall capture data_in every cycle; the candidate byte is {shift[6:0], data_in}.
REQ-012 The state machine shall have exactly three states: SEARCH, ALIGN and ACTIVE.
REQ-013 In SEARCH, a candidate byte equal to COM on any cycle shall set bit_cnt to 0 and bc_cnt to 1, then enter ALIGN; any other candidate byte leaves the state unchanged.
REQ-014 bit_cnt shall be a 3-bit counter that increments every cycle in ALIGN and ACTIVE and wraps from 7 to 0; a byte boundary is the cycle where bit_cnt == 7.
REQ-015 In ALIGN at a boundary: a COM candidate increments bc_cnt; when bc_cnt reaches BC_REQ the block enters ACTIVE. A non-COM candidate clears bc_cnt and returns to SEARCH.
REQ-016 In ALIGN, candidates at non-boundary cycles shall be ignored.
REQ-017 Entry into ACTIVE registers active=1 on the same edge; active shall stay 1 until reset.
REQ-018 In ACTIVE at each boundary, byte_strobe shall be 1 for that one cycle.
REQ-019 In ACTIVE at each boundary, a COM or IDL candidate shall set valid_out=0 and hold data_out unchanged.
REQ-020 In ACTIVE at each boundary, any other candidate shall load data_out with that candidate and set valid_out=1.
REQ-021 valid_out and data_out shall hold their values between boundaries, for 8 cycles.
REQ-022 Latency: outputs shall update on the same edge that samples the 8th bit of the byte, with no added pipeline stage.
REQ-023 bc_cnt shall saturate at BC_REQ and never wrap.
REQ-024 Symbol decisions in ACTIVE shall be made only at boundaries, so a COM pattern straddling a byte boundary has no effect.

Reset
REQ-025 While reset=0 at a clock edge: state=SEARCH, shift=0, bit_cnt=0, bc_cnt=0, data_out=8'h00, valid_out=0, byte_strobe=0, active=0.
REQ-026 Reset asserted mid-byte or mid-alignment shall discard all partial progress; realignment starts from SEARCH after release.
REQ-027 The first bit sampled on the edge after reset release shall enter the shift register.

Structure
REQ-028 COM, IDL and BC_REQ defaults and the state encodings shall live in the shared lane-symbol include used by paralelo_serial, so TX and RX agree.
REQ-029 No sub-module: a single flat module holding shift register, counters and FSM.
REQ-030 All outputs shall be registered.

Verification
REQ-031 Reset held 3 cycles while data_in toggles -> all outputs 0 during reset and on the first cycle after release.
REQ-032 Three random bits, then 4x 8'hBC, then 8'hA5 -> active rises on the edge sampling the last bit of the 4th BC; 8 cycles later data_out=8'hA5, valid_out=1, byte_strobe pulses once.
REQ-033 3x 8'hBC, then 8'h55, then 4x 8'hBC -> active stays 0 through the 8'h55 byte and rises only at the end of the second BC burst.
REQ-034 Active lane receiving 8'h3C, 8'h7C, 8'hBC, 8'hF0 -> valid_out sequence 1,0,0,1; data_out sequence 3C,3C,3C,F0; byte_strobe period of 8 cycles.
REQ-035 Reset pulsed mid-byte while active -> active=0 next cycle, and a fresh 4x BC is needed to reactivate.
REQ-036 Loopback with paralelo_serial (clk_32f shared, 32 random bytes) -> received valid byte stream equals transmitted valid bytes in order.

Source files
------------

// File: rtl/serial_paralelo_pkg.sv
// Shared lane-symbol definitions: line symbols, alignment depth and
// receiver state encodings, imported by both transmitter and receiver.
package serial_paralelo_pkg;

  // Comma symbol sent while the transmitter is inactive
  localparam logic [7:0] LANE_COM    = 8'hBC;
  // Idle symbol sent while active with no valid data
  localparam logic [7:0] LANE_IDL    = 8'h7C;
  // Consecutive aligned commas needed to declare the lane active
  localparam int unsigned LANE_BC_REQ = 4;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } rx_state_t;

  // True when a symbol is line filler (comma or idle) rather than data
  function automatic logic is_fill_sym(input logic [7:0] sym,
                                       input logic [7:0] com,
                                       input logic [7:0] idl);
    return (sym == com) || (sym == idl);
  endfunction

endpackage

// File: rtl/serial_paralelo.sv
// Serial-to-parallel lane receiver: hunts for the comma symbol, locks byte
// alignment after BC_REQ aligned commas, then delivers data bytes at every
// byte boundary. All outputs are registered and update on the edge that
// samples the last bit of each byte.
module serial_paralelo
  import serial_paralelo_pkg::*;
#(
  parameter logic [7:0]  COM    = LANE_COM,
  parameter logic [7:0]  IDL    = LANE_IDL,
  parameter int unsigned BC_REQ = LANE_BC_REQ
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam int unsigned    BC_W   = $clog2(BC_REQ + 1);
  localparam logic [BC_W-1:0] BC_MAX = BC_W'(BC_REQ);
  localparam logic [BC_W-1:0] BC_ONE = BC_W'(1);

  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  logic [6:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic [2:0]       w_bit_cnt_nxt;
  logic [BC_W-1:0]  r_bc_cnt;
  logic [BC_W-1:0]  w_bc_cnt_nxt;
  logic [7:0]       r_data;
  logic [7:0]       w_data_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_strobe;
  logic             w_strobe_nxt;
  logic             r_active;
  logic             w_active_nxt;

  logic [7:0]       w_cand;
  logic             w_boundary;
  logic             w_is_com;
  logic [BC_W-1:0]  w_bc_inc;

  assign w_cand     = {r_shift, data_in};
  assign w_boundary = (r_bit_cnt == 3'd7);
  assign w_is_com   = (w_cand == COM);
  assign w_bc_inc   = r_bc_cnt + BC_ONE;

  // Serial history: keep the previous seven lane bits
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      r_shift <= 7'd0;
    end else begin
      r_shift <= w_cand[6:0];
    end
  end

  // State, counters and output registers
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      r_state   <= ST_SEARCH;
      r_bit_cnt <= 3'd0;
      r_bc_cnt  <= '0;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_strobe  <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_bc_cnt  <= w_bc_cnt_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_strobe  <= w_strobe_nxt;
      r_active  <= w_active_nxt;
    end
  end

  // Next-state and next-output decisions; symbols only matter at boundaries
  // once a comma has been seen, so straddling comma patterns are ignored
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_bc_cnt_nxt  = r_bc_cnt;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid;
    w_strobe_nxt  = 1'b0;
    w_active_nxt  = r_active;

    case (r_state)
      ST_SEARCH: begin
        if (w_is_com) begin
          w_bit_cnt_nxt = 3'd0;
          w_bc_cnt_nxt  = BC_ONE;
          if (BC_ONE >= BC_MAX) begin
            w_state_nxt  = ST_ACTIVE;
            w_active_nxt = 1'b1;
          end else begin
            w_state_nxt  = ST_ALIGN;
          end
        end else begin
          w_state_nxt = ST_SEARCH;
        end
      end

      ST_ALIGN: begin
        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        if (w_boundary) begin
          if (w_is_com) begin
            if (r_bc_cnt < BC_MAX) begin
              w_bc_cnt_nxt = w_bc_inc;
            end else begin
              w_bc_cnt_nxt = r_bc_cnt;
            end
            if (r_bc_cnt >= (BC_MAX - BC_ONE)) begin
              w_state_nxt  = ST_ACTIVE;
              w_active_nxt = 1'b1;
            end else begin
              w_state_nxt  = ST_ALIGN;
            end
          end else begin
            w_bc_cnt_nxt = '0;
            w_state_nxt  = ST_SEARCH;
          end
        end else begin
          w_state_nxt = ST_ALIGN;
        end
      end

      ST_ACTIVE: begin
        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        if (w_boundary) begin
          w_strobe_nxt = 1'b1;
          if (is_fill_sym(w_cand, COM, IDL)) begin
            w_valid_nxt = 1'b0;
          end else begin
            w_data_nxt  = w_cand;
            w_valid_nxt = 1'b1;
          end
        end else begin
          w_strobe_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt   = ST_SEARCH;
        w_bit_cnt_nxt = 3'd0;
        w_bc_cnt_nxt  = '0;
      end
    endcase
  end

  assign data_out    = r_data;
  assign valid_out   = r_valid;
  assign byte_strobe = r_strobe;
  assign active      = r_active;

endmodule

// File: tb/tb_serial_paralelo.sv
// Self-checking bench for serial_paralelo: directed alignment scenarios,
// random noise and a behavioural transmitter stream, all compared cycle by
// cycle against a bit-window reference model.
module tb_serial_paralelo;

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] IDL = 8'h7C;
  localparam int         BCR = 4;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  int n_checks  = 0;
  int n_err     = 0;
  int n_strobes = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  // Reference model: last eight lane bits, mode, bits since comma lock
  int         m_mode;   // 0 hunting, 1 counting commas, 2 delivering
  int         m_since;
  int         m_coms;
  logic [7:0] m_win;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_strobe;
  logic       m_active;

  serial_paralelo dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .byte_strobe(byte_strobe),
    .active     (active)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task model_step(input logic in_reset, input logic b);
    if (in_reset) begin
      m_mode = 0; m_since = 0; m_coms = 0; m_win = 8'h00;
      m_data = 8'h00; m_valid = 1'b0; m_strobe = 1'b0; m_active = 1'b0;
    end else begin
      m_win    = {m_win[6:0], b};
      m_strobe = 1'b0;
      if (m_mode == 0) begin
        if (m_win == COM) begin
          m_mode = 1; m_since = 0; m_coms = 1;
          if (m_coms >= BCR) begin m_mode = 2; m_active = 1'b1; end
        end
      end else begin
        m_since++;
        if ((m_since % 8) == 0) begin
          if (m_mode == 1) begin
            if (m_win == COM) begin
              if (m_coms < BCR) m_coms++;
              if (m_coms >= BCR) begin m_mode = 2; m_active = 1'b1; end
            end else begin
              m_coms = 0; m_mode = 0;
            end
          end else begin
            m_strobe = 1'b1;
            if (m_win == COM || m_win == IDL) begin
              m_valid = 1'b0;
            end else begin
              m_data = m_win; m_valid = 1'b1;
            end
          end
        end
      end
    end
  endtask

  // One clock: drive inputs, advance model, sample outputs after the edge
  task step(input logic rst_n_v, input logic b);
    reset   = rst_n_v;
    data_in = b;
    model_step(!rst_n_v, b);
    @(posedge clk_32f);
    #1;
    chk("data_out",    32'(data_out),    32'(m_data));
    chk("valid_out",   32'(valid_out),   32'(m_valid));
    chk("byte_strobe", 32'(byte_strobe), 32'(m_strobe));
    chk("active",      32'(active),      32'(m_active));
    if (byte_strobe) n_strobes++;
    if (byte_strobe && valid_out) rx_q.push_back(data_out);
  endtask

  task send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(1'b1, v[i]);
  endtask

  task do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    logic [7:0] c;
    logic [7:0] d;
    c = COM;

    // Reset held three cycles with toggling data, then first released cycle
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'(i % 2));
      chk("rst_active", 32'(active), 32'd0);
      chk("rst_valid",  32'(valid_out), 32'd0);
      chk("rst_data",   32'(data_out), 32'd0);
      chk("rst_strobe", 32'(byte_strobe), 32'd0);
    end
    step(1'b1, 1'b1);
    chk("rel_active", 32'(active), 32'd0);
    chk("rel_valid",  32'(valid_out), 32'd0);
    chk("rel_data",   32'(data_out), 32'd0);
    chk("rel_strobe", 32'(byte_strobe), 32'd0);

    // Three random bits, four commas, then A5
    do_reset(2);
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++) send_byte(COM);
    for (int i = 7; i >= 1; i--) step(1'b1, c[i]);
    chk("act_before_last_bit", 32'(active), 32'd0);
    step(1'b1, c[0]);
    chk("act_rise", 32'(active), 32'd1);
    chk("act_rise_strobe", 32'(byte_strobe), 32'd0);
    send_byte(8'hA5);
    chk("a5_data",   32'(data_out), 32'hA5);
    chk("a5_valid",  32'(valid_out), 32'd1);
    chk("a5_strobe", 32'(byte_strobe), 32'd1);
    step(1'b1, 1'b0);
    chk("a5_strobe_once", 32'(byte_strobe), 32'd0);
    chk("a5_hold", 32'(data_out), 32'hA5);

    // Broken comma burst restarts alignment
    do_reset(2);
    for (int i = 0; i < 3; i++) send_byte(COM);
    send_byte(8'h55);
    chk("broken_burst", 32'(active), 32'd0);
    for (int i = 0; i < 3; i++) send_byte(COM);
    chk("second_burst_3", 32'(active), 32'd0);
    send_byte(COM);
    chk("second_burst_4", 32'(active), 32'd1);

    // Data / filler sequencing on an active lane
    n_strobes = 0;
    send_byte(8'h3C);
    chk("seq0_valid", 32'(valid_out), 32'd1); chk("seq0_data", 32'(data_out), 32'h3C);
    chk("seq0_strobe", 32'(byte_strobe), 32'd1);
    send_byte(8'h7C);
    chk("seq1_valid", 32'(valid_out), 32'd0); chk("seq1_data", 32'(data_out), 32'h3C);
    send_byte(8'hBC);
    chk("seq2_valid", 32'(valid_out), 32'd0); chk("seq2_data", 32'(data_out), 32'h3C);
    send_byte(8'hF0);
    chk("seq3_valid", 32'(valid_out), 32'd1); chk("seq3_data", 32'(data_out), 32'hF0);
    chk("seq3_strobe", 32'(byte_strobe), 32'd1);
    chk("strobe_period", 32'(n_strobes), 32'd4);

    // Reset mid-byte while active
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("midrst_active", 32'(active), 32'd0);
    for (int i = 0; i < 3; i++) send_byte(COM);
    chk("realign_3", 32'(active), 32'd0);
    send_byte(COM);
    chk("realign_4", 32'(active), 32'd1);

    // Random noise on the lane, model-checked every cycle
    do_reset(2);
    for (int i = 0; i < 400; i++) step(1'b1, 1'($urandom_range(0, 1)));

    // Behavioural transmitter stream: commas, then data with random idles
    for (int rep = 0; rep < 2; rep++) begin
      do_reset(2);
      rx_q.delete();
      tx_q.delete();
      for (int i = 0; i < 4 + $urandom_range(0, 2); i++) send_byte(COM);
      for (int i = 0; i < 32; i++) begin
        for (int k = 0; k < $urandom_range(0, 2); k++) send_byte(IDL);
        d = 8'($urandom_range(0, 255));
        if (d == COM || d == IDL) d = d ^ 8'h01;
        tx_q.push_back(d);
        send_byte(d);
      end
      send_byte(IDL);
      chk("loop_len", 32'(rx_q.size()), 32'(tx_q.size()));
      for (int i = 0; i < tx_q.size(); i++) begin
        if (i < rx_q.size()) chk("loop_byte", 32'(rx_q[i]), 32'(tx_q[i]));
        else chk("loop_byte_missing", 32'hDEAD, 32'(tx_q[i]));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
